// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud-rate helper
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Shared with the transmit side so both ends agree on bit length.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset level
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic res,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (res) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style UART receiver, LSB first, one-cycle valid strobe
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 921600,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_rate
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("uart_rx: DATA_WIDTH must be at least 2");
    end

    uart_state_t           state;
    uart_state_t           next_state;
    logic                  rx_s;
    logic [1:0]            settle;
    logic                  sync_ok;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  half_tick;
    logic                  bit_tick;
    logic                  last_bit;
    logic                  valid_d;
    logic                  frame_err_d;
    logic                  busy_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .res(res),
        .d  (rx),
        .q  (rx_s)
    );

    // The synchronizer leaves reset at 1, so its output only reflects the pin
    // two cycles later; WAIT_IDLE must not trust it before then.
    always_ff @(posedge clk) begin
        if (res) begin
            settle <= 2'b00;
        end else begin
            settle <= {settle[0], 1'b1};
        end
    end
    assign sync_ok = settle[1];

    assign half_tick = (cnt == CNT_W'(HALF_BIT - 1));
    assign bit_tick  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_idx == BIT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (res) begin
            state <= WAIT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_IDLE: if (rx_s && sync_ok) next_state = IDLE;
            IDLE:      if (!rx_s) next_state = START;
            START:     if (half_tick) next_state = rx_s ? IDLE : DATA;
            DATA:      if (bit_tick && last_bit) next_state = STOP;
            STOP:      if (bit_tick) next_state = rx_s ? IDLE : WAIT_IDLE;
            default:   next_state = WAIT_IDLE;
        endcase
    end

    always_comb begin
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = (next_state == START) || (next_state == DATA) || (next_state == STOP);
        if (state == STOP && bit_tick) begin
            valid_d     = rx_s;
            frame_err_d = !rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= valid_d;
            frame_err <= frame_err_d;
            busy      <= busy_d;
            if (valid_d) begin
                data <= shreg;
            end
            case (state)
                START: begin
                    if (half_tick) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        bit_idx <= bit_idx + BIT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a serial-line model
module tb_uart_rx;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int W        = 8;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    // Pin-to-strobe delay: 2 synchronizer cycles, half-bit start check,
    // W data bits plus stop bit, one register stage.
    localparam int FRAME_LAT = 2 + HALF + (W + 1) * CPB + 1;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         rx  = 1'b1;
    logic [W-1:0] data;
    logic         valid;
    logic         frame_err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int both_cnt = 0;

    logic [W-1:0] v_data_q[$];
    int           v_cyc_q[$];
    int           f_cyc_q[$];
    logic         busy_log [0:65535];

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .DATA_WIDTH(W)
    ) dut (
        .clk      (clk),
        .res      (res),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 65536) busy_log[cyc] = busy;
        if (valid) begin
            v_data_q.push_back(data);
            v_cyc_q.push_back(cyc);
        end
        if (frame_err) f_cyc_q.push_back(cyc);
        if (valid && frame_err) both_cnt++;
    end

    task automatic clear_logs();
        v_data_q.delete();
        v_cyc_q.delete();
        f_cyc_q.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] b, input logic stop_bit, output int start_cyc);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < W; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        res = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        res = 1'b0;
        idle(2 * CPB);
    endtask

    task automatic test_single_frame();
        int p;
        int busy_sum;
        clear_logs();
        send_frame(8'h55, 1'b1, p);
        idle(20);
        n_checks++; if (v_cyc_q.size() !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d expected 1", v_cyc_q.size()); end
        if (v_cyc_q.size() >= 1) begin
            n_checks++; if (v_cyc_q[0] !== p + FRAME_LAT) begin n_fail++; $display("FAIL single_latency: got cycle %0d expected %0d", v_cyc_q[0], p + FRAME_LAT); end
            n_checks++; if (v_data_q[0] !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h expected 55", v_data_q[0]); end
        end
        n_checks++; if (f_cyc_q.size() !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", f_cyc_q.size()); end
        n_checks++; if (busy_log[p + 2] !== 1'b0) begin n_fail++; $display("FAIL single_busy_before: got %b expected 0", busy_log[p + 2]); end
        busy_sum = 0;
        for (int k = p + 3; k < p + FRAME_LAT; k++) busy_sum += int'(busy_log[k]);
        n_checks++; if (busy_sum !== FRAME_LAT - 3) begin n_fail++; $display("FAIL single_busy_span: got %0d expected %0d", busy_sum, FRAME_LAT - 3); end
        n_checks++; if (busy_log[p + FRAME_LAT] !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy_log[p + FRAME_LAT]); end
        n_checks++; if (data !== 8'h55) begin n_fail++; $display("FAIL single_data_held: got %h expected 55", data); end
    endtask

    task automatic test_back_to_back();
        int p0;
        int p1;
        clear_logs();
        send_frame(8'hA3, 1'b1, p0);
        send_frame(8'h00, 1'b1, p1);
        idle(20);
        n_checks++; if (v_cyc_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", v_cyc_q.size()); end
        if (v_cyc_q.size() >= 2) begin
            n_checks++; if (v_cyc_q[1] - v_cyc_q[0] !== (W + 2) * CPB) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", v_cyc_q[1] - v_cyc_q[0], (W + 2) * CPB); end
            n_checks++; if (v_data_q[0] !== 8'hA3) begin n_fail++; $display("FAIL b2b_first: got %h expected a3", v_data_q[0]); end
            n_checks++; if (v_data_q[1] !== 8'h00) begin n_fail++; $display("FAIL b2b_second: got %h expected 00", v_data_q[1]); end
        end
    endtask

    task automatic test_glitch();
        int p;
        clear_logs();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        n_checks++; if (v_cyc_q.size() + f_cyc_q.size() !== 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", v_cyc_q.size() + f_cyc_q.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        send_frame(8'h3C, 1'b1, p);
        idle(20);
        n_checks++; if (v_cyc_q.size() !== 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d expected 1", v_cyc_q.size()); end
        if (v_cyc_q.size() >= 1) begin
            n_checks++; if (v_data_q[0] !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_data: got %h expected 3c", v_data_q[0]); end
        end
    endtask

    task automatic test_frame_error();
        int p;
        clear_logs();
        send_frame(8'h12, 1'b0, p);
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        idle(2 * CPB);
        n_checks++; if (f_cyc_q.size() !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", f_cyc_q.size()); end
        if (f_cyc_q.size() >= 1) begin
            n_checks++; if (f_cyc_q[0] !== p + FRAME_LAT) begin n_fail++; $display("FAIL ferr_latency: got cycle %0d expected %0d", f_cyc_q[0], p + FRAME_LAT); end
        end
        n_checks++; if (v_cyc_q.size() !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d expected 0", v_cyc_q.size()); end
        n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected 3c", data); end
        send_frame(8'h7E, 1'b1, p);
        idle(20);
        n_checks++; if (v_cyc_q.size() !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d expected 1", v_cyc_q.size()); end
        if (v_cyc_q.size() >= 1) begin
            n_checks++; if (v_data_q[0] !== 8'h7E) begin n_fail++; $display("FAIL ferr_recover_data: got %h expected 7e", v_data_q[0]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int p;
        int r;
        int busy_sum;
        clear_logs();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        rx  = 1'b0;
        res = 1'b1;
        @(negedge clk);
        n_checks++; if (data !== '0) begin n_fail++; $display("FAIL midreset_data: got %h expected 00", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        res = 1'b0;
        r = cyc;
        repeat (3 * CPB) @(negedge clk);
        busy_sum = 0;
        for (int k = r; k < cyc; k++) busy_sum += int'(busy_log[k]);
        n_checks++; if (busy_sum !== 0) begin n_fail++; $display("FAIL midreset_false_start: got %0d busy cycles expected 0", busy_sum); end
        n_checks++; if (v_cyc_q.size() + f_cyc_q.size() !== 0) begin n_fail++; $display("FAIL midreset_strobes: got %0d expected 0", v_cyc_q.size() + f_cyc_q.size()); end
        idle(CPB);
        send_frame(8'h81, 1'b1, p);
        idle(20);
        n_checks++; if (v_cyc_q.size() !== 1) begin n_fail++; $display("FAIL midreset_next_count: got %0d expected 1", v_cyc_q.size()); end
        if (v_cyc_q.size() >= 1) begin
            n_checks++; if (v_data_q[0] !== 8'h81) begin n_fail++; $display("FAIL midreset_next_data: got %h expected 81", v_data_q[0]); end
            n_checks++; if (v_cyc_q[0] !== p + FRAME_LAT) begin n_fail++; $display("FAIL midreset_next_latency: got cycle %0d expected %0d", v_cyc_q[0], p + FRAME_LAT); end
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] b;
        int p;
        int n;
        clear_logs();
        for (int i = 0; i < 256; i++) begin
            b = W'($urandom_range(0, (1 << W) - 1));
            exp_q.push_back(b);
            send_frame(b, 1'b1, p);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, CPB));
        end
        idle(20);
        n_checks++; if (v_data_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL loop_count: got %0d expected %0d", v_data_q.size(), exp_q.size()); end
        n = (v_data_q.size() < exp_q.size()) ? v_data_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++; if (v_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL loop_data[%0d]: got %h expected %h", i, v_data_q[i], exp_q[i]); end
        end
        n_checks++; if (f_cyc_q.size() !== 0) begin n_fail++; $display("FAIL loop_frame_err: got %0d expected 0", f_cyc_q.size()); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_and_frame_err_together: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver (8N1-style, LSB first). It is the receive-side counterpart of the existing uart_tx/uart path that drains the debugger ring buffer.
- Converts an asynchronous `rx` line into parallel words, each announced by a one-cycle `valid` strobe.
- Intended to sit beside the uart instance at the top of a system, feeding host commands or data inward, e.g. into a ring buffer or a controller.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 921600: line rate in bit/s.
- DATA_WIDTH, 8: data bits per frame.
- Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD, truncating division (108 at defaults).
- Derived localparam HALF_BIT = CLKS_PER_BIT/2, truncating.
- Elaboration error if CLKS_PER_BIT < 4.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- res  in  1  synchronous active-high reset.
- rx  in  1  asynchronous serial input; idle level is high.
- data  out  DATA_WIDTH  last correctly framed word; held until the next good frame.
- valid  out  1  one-cycle strobe: `data` was updated this cycle.
- frame_err  out  1  one-cycle strobe: stop bit was sampled low.
- busy  out  1  high while a frame is in progress (START, DATA, STOP).

Behaviour:
- Synchronizer: `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- Reset values:
  - data=0, valid=0, frame_err=0, busy=0.
  - state=WAIT_IDLE; bit counter and baud counter = 0.
- WAIT_IDLE:
  - stay while rx_s==0; go to IDLE when rx_s==1.
  - Purpose: guarantees no false frame after reset, or after a break or line held low.
- IDLE: when rx_s==0, go to START with baud counter cnt=0. Call this cycle c.
- START:
  - increment cnt; at cnt==HALF_BIT-1 (cycle c+HALF_BIT) sample rx_s.
  - rx_s==0: go to DATA, cnt=0, bit index=0.
  - rx_s==1: glitch; return to IDLE, no strobes.
- DATA:
  - at cnt==CLKS_PER_BIT-1, sample rx_s into the shift register (shift right, new bit enters at the MSB) and reset cnt to 0.
  - after DATA_WIDTH samples, go to STOP. Bit k is sampled at cycle c+HALF_BIT+(k+1)*CLKS_PER_BIT.
- STOP: at cnt==CLKS_PER_BIT-1 (cycle c+HALF_BIT+(DATA_WIDTH+1)*CLKS_PER_BIT), sample rx_s.
  - rx_s==1: load data from the shift register, pulse valid next cycle, go to IDLE.
  - rx_s==0: pulse frame_err next cycle, leave data unchanged, go to WAIT_IDLE.
- Latency: valid/frame_err are registered and high exactly in cycle c+1+HALF_BIT+(DATA_WIDTH+1)*CLKS_PER_BIT, for one cycle only.
- valid and frame_err are never high in the same cycle.
- Back-to-back frames: a start edge arriving immediately after mid-stop is accepted. IDLE is reentered right after the STOP sample, so the next start bit is never missed.
- No downstream backpressure. A consumer that misses a valid strobe loses the word; there is no overrun flag.
- busy is registered and equals (state in START/DATA/STOP).
- Reset mid-frame: the same-cycle response is as for reset (all outputs zero, state WAIT_IDLE). The partial word is discarded.

Decomposition:
- Package uart_pkg:
  - state enum {WAIT_IDLE, IDLE, START, DATA, STOP}.
  - function clks_per_bit(clk_freq, baud).
  - The same function is reused by uart_clk/uart_tx for consistency.
- Sub-module sync_2ff: parameterised reset value, here 1. The rest of the logic (FSM, baud counter, bit counter, shift register) stays in uart_rx.

Test Plan (all use CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16 and HALF_BIT=8, DATA_WIDTH=8):
1. Send frame 0x55 (start, 10101010 LSB first, stop 1), with c = the cycle IDLE sees rx_s low -> valid high only at c+153, data=0x55, frame_err=0, busy high c+1..c+152.
2. Send 0xA3 then 0x00 with no idle gap (start bit begins right after the stop bit) -> two valid pulses 160 cycles apart, data 0xA3 then 0x00.
3. Pulse rx low for 4 cycles, then high -> START aborts at the half-bit check, no valid/frame_err, busy returns to 0, and the next 0x3C frame is received correctly.
4. Send 0x12 with the stop bit low and hold rx low for 40 further bit times -> frame_err pulses once, data keeps its previous value, no valid. After rx returns high, 0x7E is received with valid.
5. Assert res during DATA of 0xFF while driving rx low through the release of res -> outputs 0 from the reset cycle; no frame starts until rx is high at least 1 bit; then 0x81 is received correctly.
6. Loopback against uart_tx at matching parameters over 256 random bytes -> every byte is received in order, with zero frame_err.
